// File: rtl/mexp_pkg.sv
// Shared types for the modular-exponentiation operand sequencer.
// Optional feature macro used by the top: MEXP_SKIP_LEADING_ZEROS_EN.
package mexp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SQR,
        SQR_W,
        MUL,
        MUL_W,
        FIN
    } state_e;

    typedef enum logic [1:0] {
        SRC_ONE,
        SRC_BASE,
        SRC_ACC,
        SRC_ZERO
    } src_e;

endpackage

// File: rtl/operand_mux.sv
// WIDTH-parametrised 4:1 operand selector driven by the source code.
module operand_mux
    import mexp_pkg::*;
#(
    parameter int unsigned WIDTH = 10
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] one,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] y
);

    // Pure selection; the caller registers the output.
    always_comb begin
        y = '0;
        case (sel)
            SRC_ONE:  y = one;
            SRC_BASE: y = base;
            SRC_ACC:  y = acc;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/mexp_operand_seq.sv
// Left-to-right square-and-multiply sequencer feeding an external
// Montgomery multiplier over valid/ready. Optional macro
// MEXP_SKIP_LEADING_ZEROS_EN adds a one-cycle SCAN that skips the
// exponent's leading zeros.
module mexp_operand_seq
    import mexp_pkg::*;
#(
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned EXP_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [WIDTH-1:0]     one_val,
    input  logic [EXP_WIDTH-1:0] exponent,
    output logic                 busy,
    output logic                 mul_valid,
    input  logic                 mul_ready,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic                 res_valid,
    input  logic [WIDTH-1:0]     res_data,
    output logic                 done,
    output logic [WIDTH-1:0]     result
);

    localparam int unsigned IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_WIDTH - 1);

    state_e               state;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     base_r;
    logic [WIDTH-1:0]     one_r;
    logic [EXP_WIDTH-1:0] exp_r;
    logic [IDX_W-1:0]     idx;

    logic [WIDTH-1:0]     acc_n_c;
    logic [WIDTH-1:0]     base_n_c;
    logic [WIDTH-1:0]     mux_a_c;
    logic [WIDTH-1:0]     mux_b_c;
    src_e                 src_a_c;
    src_e                 src_b_c;
    logic                 issue_c;
    logic                 bit_c;
    logic                 last_c;

    assign bit_c  = exp_r[idx];
    assign last_c = (idx == '0);

`ifdef MEXP_SKIP_LEADING_ZEROS_EN
    logic [IDX_W-1:0] msb_c;

    // Priority encoder: index of the highest set exponent bit.
    always_comb begin
        msb_c = '0;
        for (int i = 0; i < int'(EXP_WIDTH); i++) begin
            if (exp_r[i]) msb_c = IDX_W'(i);
        end
    end
`endif

    // Operand sources and accumulator value for the cycle after this edge,
    // so the registered operands line up with mul_valid and stay put on a stall.
    always_comb begin
        acc_n_c  = acc;
        base_n_c = base_r;
        src_a_c  = SRC_ZERO;
        src_b_c  = SRC_ZERO;
        issue_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_n_c  = one_val;
                    base_n_c = base;
`ifndef MEXP_SKIP_LEADING_ZEROS_EN
                    issue_c  = 1'b1;
                    src_a_c  = SRC_ACC;
                    src_b_c  = SRC_ACC;
`endif
                end
            end
`ifdef MEXP_SKIP_LEADING_ZEROS_EN
            SCAN: begin
                if (exp_r != '0) begin
                    acc_n_c = base_r;
                    if (msb_c != '0) begin
                        issue_c = 1'b1;
                        src_a_c = SRC_ACC;
                        src_b_c = SRC_ACC;
                    end
                end
            end
`endif
            SQR: begin
                if (!mul_ready) begin
                    issue_c = 1'b1;
                    src_a_c = SRC_ACC;
                    src_b_c = SRC_ACC;
                end
            end
            SQR_W: begin
                if (res_valid) begin
                    acc_n_c = res_data;
                    if (bit_c) begin
                        issue_c = 1'b1;
                        src_a_c = SRC_ACC;
                        src_b_c = SRC_BASE;
                    end else if (!last_c) begin
                        issue_c = 1'b1;
                        src_a_c = SRC_ACC;
                        src_b_c = SRC_ACC;
                    end
                end
            end
            MUL: begin
                if (!mul_ready) begin
                    issue_c = 1'b1;
                    src_a_c = SRC_ACC;
                    src_b_c = SRC_BASE;
                end
            end
            MUL_W: begin
                if (res_valid) begin
                    acc_n_c = res_data;
                    if (!last_c) begin
                        issue_c = 1'b1;
                        src_a_c = SRC_ACC;
                        src_b_c = SRC_ACC;
                    end
                end
            end
            default: ;
        endcase
    end

    operand_mux #(.WIDTH(WIDTH)) u_mux_a (
        .sel  (src_a_c),
        .one  (one_r),
        .base (base_n_c),
        .acc  (acc_n_c),
        .y    (mux_a_c)
    );

    operand_mux #(.WIDTH(WIDTH)) u_mux_b (
        .sel  (src_b_c),
        .one  (one_r),
        .base (base_n_c),
        .acc  (acc_n_c),
        .y    (mux_b_c)
    );

    // Sequencer state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            base_r    <= '0;
            one_r     <= '0;
            exp_r     <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            mul_valid <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            done      <= 1'b0;
            mul_valid <= issue_c;
            mul_a     <= mux_a_c;
            mul_b     <= mux_b_c;
            acc       <= acc_n_c;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_r <= base;
                        one_r  <= one_val;
                        exp_r  <= exponent;
                        idx    <= IDX_TOP;
                        busy   <= 1'b1;
`ifdef MEXP_SKIP_LEADING_ZEROS_EN
                        state  <= SCAN;
`else
                        state  <= SQR;
`endif
                    end
                end
                SCAN: begin
`ifdef MEXP_SKIP_LEADING_ZEROS_EN
                    if (exp_r == '0 || msb_c == '0) begin
                        state <= FIN;
                    end else begin
                        idx   <= msb_c - IDX_W'(1);
                        state <= SQR;
                    end
`else
                    state <= IDLE;
`endif
                end
                SQR: begin
                    if (mul_valid && mul_ready) state <= SQR_W;
                end
                SQR_W: begin
                    if (res_valid) begin
                        if (bit_c) begin
                            state <= MUL;
                        end else if (last_c) begin
                            state <= FIN;
                        end else begin
                            idx   <= idx - IDX_W'(1);
                            state <= SQR;
                        end
                    end
                end
                MUL: begin
                    if (mul_valid && mul_ready) state <= MUL_W;
                end
                MUL_W: begin
                    if (res_valid) begin
                        if (last_c) begin
                            state <= FIN;
                        end else begin
                            idx   <= idx - IDX_W'(1);
                            state <= SQR;
                        end
                    end
                end
                FIN: begin
                    done   <= 1'b1;
                    result <= acc;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mexp_operand_seq.sv
// Scoreboard bench for mexp_operand_seq: modular multiplier model
// (mod 1009) with random ready/latency, directed exponentiation vectors.
module tb_mexp_operand_seq;

    localparam int WIDTH     = 10;
    localparam int EXP_WIDTH = 8;
    localparam int MOD       = 1009;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [WIDTH-1:0]     base;
    logic [WIDTH-1:0]     one_val;
    logic [EXP_WIDTH-1:0] exponent;
    logic                 busy;
    logic                 mul_valid;
    logic                 mul_ready;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic                 res_valid;
    logic [WIDTH-1:0]     res_data;
    logic                 done;
    logic [WIDTH-1:0]     result;

    mexp_operand_seq #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base      (base),
        .one_val   (one_val),
        .exponent  (exponent),
        .busy      (busy),
        .mul_valid (mul_valid),
        .mul_ready (mul_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .res_valid (res_valid),
        .res_data  (res_data),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        int ops;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   hs_count = 0;
    int   done_count = 0;
    int   cyc = 0;
    int   done_cyc = 0;
    int   stall_req = 0;
    int   hold_at = -1;
    bit   hold_resp = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: random ready, random response latency, stall checks.
    initial begin
        bit               pend;
        bit               prev_stall;
        int               lat;
        int               stall_left;
        logic [WIDTH-1:0] pend_val;
        logic [WIDTH-1:0] prev_a;
        logic [WIDTH-1:0] prev_b;
        pend = 1'b0;
        prev_stall = 1'b0;
        lat = 0;
        stall_left = 0;
        pend_val = '0;
        prev_a = '0;
        prev_b = '0;
        mul_ready = 1'b0;
        res_valid = 1'b0;
        res_data = '0;
        forever begin
            @(negedge clk);
            if (prev_stall && !rst) begin
                check("stall_valid", int'(mul_valid), 1);
                check("stall_a", int'(mul_a), int'(prev_a));
                check("stall_b", int'(mul_b), int'(prev_b));
            end
            res_valid = 1'b0;
            if (pend) begin
                if (lat == 0 && !hold_resp) begin
                    res_valid = 1'b1;
                    res_data = pend_val;
                    pend = 1'b0;
                end else if (lat > 0) begin
                    lat--;
                end
            end
            if (stall_req > 0 && mul_valid) begin
                stall_left = stall_req;
                stall_req = 0;
            end
            if (stall_left > 0) begin
                mul_ready = 1'b0;
                stall_left--;
            end else begin
                mul_ready = ($urandom_range(0, 2) != 0);
            end
            if (mul_valid && mul_ready && !rst) begin
                pend = 1'b1;
                lat = $urandom_range(0, 3);
                pend_val = WIDTH'((int'(mul_a) * int'(mul_b)) % MOD);
                hs_count++;
                if (hs_count == hold_at) hold_resp = 1'b1;
            end
            prev_stall = mul_valid && !mul_ready && !rst;
            prev_a = mul_a;
            prev_b = mul_b;
        end
    end

    // Monitor: pop the expected result on every done pulse.
    initial begin
        bit   prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_count++;
                done_cyc = cyc;
                check("done_width", int'(prev_done), 0);
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("result", int'(result), e.res);
                    check("op_count", hs_count, e.ops);
                end
            end
            prev_done = (done === 1'b1);
        end
    end

    task automatic run_op(input int b, input int e, input int res, input int ops_plain,
                          input int ops_skip, input bit poke, output int lat);
        int   dc;
        int   st_cyc;
        int   n;
        exp_t x;
        @(negedge clk);
        base = WIDTH'(b);
        exponent = EXP_WIDTH'(e);
        start = 1'b1;
        hs_count = 0;
        x.res = res;
`ifdef MEXP_SKIP_LEADING_ZEROS_EN
        x.ops = ops_skip;
`else
        x.ops = ops_plain;
`endif
        sb_q.push_back(x);
        dc = done_count;
        st_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
`ifndef MEXP_SKIP_LEADING_ZEROS_EN
        check("valid_after_start", int'(mul_valid), 1);
`endif
        n = 0;
        while (done_count == dc && n < 3000) begin
            @(negedge clk);
            n++;
            if (poke && n == 3) begin
                base = WIDTH'(7);
                exponent = EXP_WIDTH'(1);
                start = 1'b1;
            end else if (poke && n == 4) begin
                start = 1'b0;
            end
        end
        if (done_count == dc) check("done_timeout", 0, 1);
        lat = done_cyc - st_cyc;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int dc;
        int n;
        rst = 1'b1;
        start = 1'b0;
        base = '0;
        one_val = WIDTH'(1);
        exponent = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_mul_valid", int'(mul_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_mul_a", int'(mul_a), 0);
        check("rst_mul_b", int'(mul_b), 0);
        check("rst_result", int'(result), 0);
        rst = 1'b0;

        run_op(3, 13, 103, 11, 5, 1'b0, lat);
        run_op(9, 0, 1, 8, 0, 1'b0, lat);
`ifdef MEXP_SKIP_LEADING_ZEROS_EN
        check("exp0_done_latency", lat, 3);
`endif
        run_op(7, 1, 7, 9, 0, 1'b0, lat);
        run_op(2, 10, 15, 10, 4, 1'b0, lat);
        run_op(10, 3, 1000, 10, 2, 1'b0, lat);

        // Ready held low for five cycles on the first SQR.
        stall_req = 5;
        run_op(3, 13, 103, 11, 5, 1'b0, lat);

        // Reset while waiting on a MUL product; the late product must be ignored.
`ifdef MEXP_SKIP_LEADING_ZEROS_EN
        hold_at = 2;
`else
        hold_at = 6;
`endif
        @(negedge clk);
        base = WIDTH'(3);
        exponent = EXP_WIDTH'(13);
        start = 1'b1;
        hs_count = 0;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!hold_resp && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("hold_reached", int'(hold_resp), 1);
        repeat (2) @(negedge clk);
        check("busy_before_rst", int'(busy), 1);
        dc = done_count;
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_mul_valid", int'(mul_valid), 0);
        check("abort_done", int'(done), 0);
        check("abort_mul_a", int'(mul_a), 0);
        check("abort_mul_b", int'(mul_b), 0);
        check("abort_result", int'(result), 0);
        rst = 1'b0;
        hold_at = -1;
        hold_resp = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_done", done_count, dc);
        check("abort_idle_valid", int'(mul_valid), 0);

        run_op(5, 2, 25, 9, 1, 1'b0, lat);

        // Start pulsed while busy must not launch a second operation.
        dc = done_count;
        run_op(2, 10, 15, 10, 4, 1'b1, lat);
        repeat (40) @(negedge clk);
        check("single_done", done_count - dc, 1);
        check("result_held", int'(result), 15);
        check("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mexp_operand_seq.md
# mexp_operand_seq

Parametrised operand-select sequencer for modular exponentiation in the RSA datapath. It generalises the fixed-width 4-way operand selector (ONE / A / B / ZERO) into a registered, WIDTH-parametrised selector. An internal left-to-right square-and-multiply state machine drives the selector. It walks the exponent, issues operand pairs to the external Montgomery multiplier over a valid/ready handshake, and accumulates results until the final value is ready.

## Interface
Parameters:
- WIDTH, 10: operand/result width in bits
- EXP_WIDTH, 8: exponent width in bits

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin exponentiation; sampled only in IDLE
- base  in  WIDTH  base (Montgomery domain); latched on accepted start
- one_val  in  WIDTH  Montgomery-domain one; latched on accepted start
- exponent  in  EXP_WIDTH  exponent; latched on accepted start
- busy  out  1  high from the cycle after an accepted start through FIN
- mul_valid  out  1  operand pair valid
- mul_ready  in  1  multiplier accepts operands
- mul_a  out  WIDTH  operand A (registered)
- mul_b  out  WIDTH  operand B (registered)
- res_valid  in  1  single-cycle product-valid pulse
- res_data  in  WIDTH  product
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  final value; held until the next accepted start

## Operation
- Registers: acc, base_r, one_r, exp_r, idx (clog2(EXP_WIDTH) bits), state.
- Operand source codes: SRC_ONE, SRC_BASE, SRC_ACC, SRC_ZERO.
  - SQR issues A=ACC, B=ACC.
  - MUL issues A=ACC, B=BASE.
  - In all other states, mul_a and mul_b drive ZERO.
- States:
  - IDLE: on start, latch inputs, set acc=one_val, set idx=EXP_WIDTH-1, then go to SQR (or SCAN when the macro is enabled).
  - SQR: hold mul_valid; on mul_valid&&mul_ready go to SQR_W.
  - SQR_W: on res_valid, set acc=res_data. If exp_r[idx]=1 go to MUL. Otherwise, if idx==0 go to FIN; else decrement idx and go to SQR.
  - MUL: hold mul_valid; on mul_valid&&mul_ready go to MUL_W.
  - MUL_W: on res_valid, set acc=res_data. If idx==0 go to FIN; else decrement idx and go to SQR.
  - FIN: assert done, set result=acc, go to IDLE.
- Handshake rules:
  - While mul_valid is high without mul_ready, mul_a and mul_b must not change.
  - res_valid outside SQR_W/MUL_W is ignored.
  - start while busy is ignored.
- Exponent 0 without the macro runs EXP_WIDTH squares of one_r. The result is whatever the multiplier returns.
- Operation count without the macro: EXP_WIDTH squares plus popcount(exponent) multiplies.

## Timing
- Reset: state=IDLE. busy, mul_valid, done, mul_a, mul_b and result are all 0.
- Reset mid-operation aborts the operation; mul_valid drops on the reset edge. No done pulse is produced.
- mul_valid rises on the edge that samples start (no macro), or on the edge that samples res_valid of the previous operation.
- done rises on the edge after the final res_valid is sampled. It is high for exactly one cycle, and result is valid from that cycle.
- No combinational path from any input to any output.

## Configuration
- MEXP_SKIP_LEADING_ZEROS_EN defined:
  - IDLE goes to SCAN, which lasts one cycle and uses a priority encoder to find m = index of the highest set bit.
  - If exponent==0, go to FIN with result=one_r and no multiplier operations.
  - Otherwise set acc=base_r. If m==0 go to FIN; else set idx=m-1 and go to SQR.
  - Operation count: m squares plus popcount-1 multiplies.
- Undefined: SCAN does not exist and all EXP_WIDTH bits are processed.
- Results are identical for non-zero exponents in both builds.

## Structure
- Package mexp_pkg holds:
  - the state enum (IDLE, SCAN, SQR, SQR_W, MUL, MUL_W, FIN);
  - the 2-bit operand source enum (SRC_ONE, SRC_BASE, SRC_ACC, SRC_ZERO).
- Sub-module operand_mux: a WIDTH-parametrised 4:1 combinational selector on the source enum. It is instantiated twice (A and B), and its outputs feed the mul_a/mul_b registers.

## Test plan
Bench multiplier model: product=(a*b) mod 1009 with random ready/response latency; one_val=1.
- base=3, exponent=13 -> result=103. Without macro: 11 handshakes (8 SQR, 3 MUL). With macro: 5 handshakes (3 SQR, 2 MUL).
- exponent=0 -> result=1. With macro: no mul_valid, done 2 cycles after start is sampled. Without macro: 8 SQR handshakes.
- base=7, exponent=1, macro on -> result=7, zero handshakes.
- mul_ready held low 5 cycles during SQR -> mul_valid stays high, mul_a/mul_b stable, result still correct.
- rst pulsed in MUL_W, then res_valid arrives -> all outputs 0, no done, next start runs cleanly.
- start re-asserted while busy -> ignored; single done pulse with the original result.
